// File: rtl/kamus_lsu_ctrl_if.sv
// L1D request/grant/response bus between the LSU sequencer (master) and the data cache (slave).
interface kamus_lsu_ctrl_if;
  logic        l1d_req_o;
  logic        l1d_we_o;
  logic [31:0] l1d_addr_o;
  logic [31:0] l1d_wdata_o;
  logic [3:0]  l1d_be_o;
  logic        l1d_gnt_i;
  logic        l1d_rvalid_i;
  logic [31:0] l1d_rdata_i;

  modport master (
    output l1d_req_o, l1d_we_o, l1d_addr_o, l1d_wdata_o, l1d_be_o,
    input  l1d_gnt_i, l1d_rvalid_i, l1d_rdata_i
  );

  modport slave (
    input  l1d_req_o, l1d_we_o, l1d_addr_o, l1d_wdata_o, l1d_be_o,
    output l1d_gnt_i, l1d_rvalid_i, l1d_rdata_i
  );
endinterface

// File: rtl/kamus_lsu_ctrl.sv
// Load/store sequencer: drives the L1D req/gnt/rvalid handshake, stalls EX until the access
// completes, steers store lanes, extends load data, flags misalignment and bus timeouts.
module kamus_lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,
  input  logic [1:0] off,
  input  logic [7:0] byte8,
  input  logic [7:0] half8,
  input  logic [7:0] word8,
  output logic       be,
  output logic [7:0] wbyte
);
  localparam logic [1:0] LN = 2'(LANE);

  always_comb begin
    be    = 1'b1;
    wbyte = word8;
    case (size)
      2'b00:   begin be = (off == LN);       wbyte = byte8; end
      2'b01:   begin be = (off[1] == LN[1]); wbyte = half8; end
      default: begin be = 1'b1;              wbyte = word8; end
    endcase
  end
endmodule

module kamus_lsu_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_valid_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        flush_i,
  kamus_lsu_ctrl_if.master l1d,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);
  localparam int NUM_LANES = 4;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t      state;
  logic        req_q, we_q, done_q, err_q, drop_q, uns_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [1:0]  size_q, off_q;
  logic [CW-1:0] cnt;

  logic                        mis, accept, last;
  logic [NUM_LANES-1:0]        steer_be;
  logic [NUM_LANES-1:0][7:0]   steer_wdata;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    kamus_lsu_lane #(.LANE(i)) u_lane (
      .size  (mem_size_i),
      .off   (mem_addr_i[1:0]),
      .byte8 (mem_wdata_i[7:0]),
      .half8 (mem_wdata_i[8*(i%2) +: 8]),
      .word8 (mem_wdata_i[8*i +: 8]),
      .be    (steer_be[i]),
      .wbyte (steer_wdata[i])
    );
  end

  assign mis = (mem_size_i == 2'b01 && mem_addr_i[0]) ||
               (mem_size_i == 2'b10 && mem_addr_i[1:0] != 2'b00) ||
               (mem_size_i == 2'b11);
  assign accept       = (state == IDLE) && mem_valid_i && !mis && !flush_i;
  assign misaligned_o = (state == IDLE) && mem_valid_i && mis;
  assign stall_o      = accept || (state == REQ) || (state == RSP);
  assign last         = (cnt == CW'(TIMEOUT_CYC - 1));

  function automatic logic [31:0] ld_ext(logic [31:0] w, logic [1:0] sz, logic [1:0] off, logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   ld_ext = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   ld_ext = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: ld_ext = w;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      uns_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      case (state)
        IDLE: if (accept) begin
          state   <= REQ;
          req_q   <= 1'b1;
          we_q    <= mem_we_i;
          addr_q  <= {mem_addr_i[31:2], 2'b00};
          wdata_q <= steer_wdata;
          be_q    <= steer_be;
          size_q  <= mem_size_i;
          off_q   <= mem_addr_i[1:0];
          uns_q   <= mem_unsigned_i;
          cnt     <= '0;
          drop_q  <= 1'b0;
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (l1d.l1d_gnt_i && l1d.l1d_rvalid_i) begin
            req_q <= 1'b0;
            if (flush_i) state <= IDLE;
            else begin
              state   <= DONE;
              done_q  <= 1'b1;
              rdata_q <= we_q ? '0 : ld_ext(l1d.l1d_rdata_i, size_q, off_q, uns_q);
            end
          end else if (flush_i && !l1d.l1d_gnt_i) begin
            req_q <= 1'b0;
            state <= IDLE;
          end else if (last) begin
            // a grant in the final cycle is not a completion; the timeout still fires
            req_q <= 1'b0;
            if (flush_i) state <= IDLE;
            else begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end else if (l1d.l1d_gnt_i) begin
            req_q  <= 1'b0;
            state  <= RSP;
            drop_q <= flush_i;
          end
        end
        RSP: begin
          cnt <= cnt + 1'b1;
          if (l1d.l1d_rvalid_i) begin
            if (drop_q || flush_i) state <= IDLE;
            else begin
              state   <= DONE;
              done_q  <= 1'b1;
              rdata_q <= we_q ? '0 : ld_ext(l1d.l1d_rdata_i, size_q, off_q, uns_q);
            end
          end else if (last) begin
            if (drop_q || flush_i) state <= IDLE;
            else begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end else if (flush_i) begin
            drop_q <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign l1d.l1d_req_o   = req_q;
  assign l1d.l1d_we_o    = we_q;
  assign l1d.l1d_addr_o  = addr_q;
  assign l1d.l1d_wdata_o = wdata_q;
  assign l1d.l1d_be_o    = be_q;
  assign rdata_o         = rdata_q;
  assign done_o          = done_q;
  assign bus_err_o       = err_q;
endmodule

// File: tb/tb_kamus_lsu_ctrl.sv
// Directed bench for kamus_lsu_ctrl: table of zero-wait accesses plus hand-built wait/flush/timeout/reset sequences.
module tb_kamus_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_we, mem_uns, flush;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        gnt, rvalid;
  logic [31:0] rdata_bus;
  logic        stall, done, mis, bus_err;
  logic [31:0] rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  kamus_lsu_ctrl_if bus();
  assign bus.l1d_gnt_i    = gnt;
  assign bus.l1d_rvalid_i = rvalid;
  assign bus.l1d_rdata_i  = rdata_bus;

  kamus_lsu_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mem_valid_i    (mem_valid),
    .mem_we_i       (mem_we),
    .mem_size_i     (mem_size),
    .mem_unsigned_i (mem_uns),
    .mem_addr_i     (mem_addr),
    .mem_wdata_i    (mem_wdata),
    .flush_i        (flush),
    .l1d            (bus),
    .stall_o        (stall),
    .rdata_o        (rdata),
    .done_o         (done),
    .misaligned_o   (mis),
    .bus_err_o      (bus_err)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        mis;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    mem_valid = 1'b1;
    mem_we    = we;
    mem_size  = sz;
    mem_uns   = uns;
    mem_addr  = addr;
    mem_wdata = wd;
  endtask

  task automatic run_vec(input vec_t v);
    set_op(v.we, v.size, v.uns, v.addr, v.wdata);
    #1;
    if (v.mis) begin
      chk("mis_flag", {31'b0, mis}, 32'd1);
      chk("mis_stall", {31'b0, stall}, 32'd0);
      tick;
      chk("mis_no_req", {31'b0, bus.l1d_req_o}, 32'd0);
      mem_valid = 1'b0;
      tick;
      chk("mis_no_done", {31'b0, done}, 32'd0);
    end else begin
      chk("acc_stall", {31'b0, stall}, 32'd1);
      chk("acc_mis", {31'b0, mis}, 32'd0);
      tick;
      chk("req", {31'b0, bus.l1d_req_o}, 32'd1);
      chk("addr", bus.l1d_addr_o, v.e_addr);
      chk("be", {28'b0, bus.l1d_be_o}, {28'b0, v.e_be});
      chk("wdata", bus.l1d_wdata_o, v.e_wdata);
      chk("we", {31'b0, bus.l1d_we_o}, {31'b0, v.we});
      gnt = 1'b1; rvalid = 1'b1; rdata_bus = v.rdata;
      #1;
      chk("req_stall", {31'b0, stall}, 32'd1);
      tick;
      gnt = 1'b0; rvalid = 1'b0;
      chk("done", {31'b0, done}, 32'd1);
      chk("rdata", rdata, v.e_rdata);
      chk("done_err", {31'b0, bus_err}, 32'd0);
      chk("done_stall", {31'b0, stall}, 32'd0);
      mem_valid = 1'b0;
      tick;
      chk("done_pulse", {31'b0, done}, 32'd0);
    end
  endtask

  initial begin
    int nreq;
    vt[0]  = '{1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 32'h80FF_0000, 32'h1000, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0};
    vt[1]  = '{1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h80FF_0000, 32'h1000, 4'b1000, 32'h0, 32'h0000_0080, 1'b0};
    vt[2]  = '{1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 32'h8001_1234, 32'h2000, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0};
    vt[3]  = '{1'b0, 2'b01, 1'b1, 32'h2000, 32'h0, 32'h8001_F234, 32'h2000, 4'b0011, 32'h0, 32'h0000_F234, 1'b0};
    vt[4]  = '{1'b0, 2'b10, 1'b0, 32'h3004, 32'h0, 32'hDEAD_BEEF, 32'h3004, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0};
    vt[5]  = '{1'b0, 2'b00, 1'b0, 32'h1001, 32'h0, 32'h0000_7F00, 32'h1000, 4'b0010, 32'h0, 32'h0000_007F, 1'b0};
    vt[6]  = '{1'b1, 2'b00, 1'b0, 32'h4002, 32'h0000_00A5, 32'h1234_5678, 32'h4000, 4'b0100, 32'hA5A5_A5A5, 32'h0, 1'b0};
    vt[7]  = '{1'b1, 2'b10, 1'b0, 32'h4008, 32'h0123_4567, 32'h1234_5678, 32'h4008, 4'b1111, 32'h0123_4567, 32'h0, 1'b0};
    vt[8]  = '{1'b1, 2'b01, 1'b0, 32'h4000, 32'hFFFF_1234, 32'h0, 32'h4000, 4'b0011, 32'h1234_1234, 32'h0, 1'b0};
    vt[9]  = '{1'b0, 2'b10, 1'b0, 32'h3001, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1};
    vt[10] = '{1'b0, 2'b11, 1'b0, 32'h0000, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1};
    vt[11] = '{1'b0, 2'b01, 1'b0, 32'h3003, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1};

    rst = 1'b1; mem_valid = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_uns = 1'b0;
    mem_addr = '0; mem_wdata = '0; flush = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata_bus = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_req", {31'b0, bus.l1d_req_o}, 32'd0);
    chk("rst_addr", bus.l1d_addr_o, 32'd0);
    chk("rst_be", {28'b0, bus.l1d_be_o}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);

    foreach (vt[i]) run_vec(vt[i]);

    // SH with grant after 3 wait cycles and response two cycles after grant
    set_op(1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000_BEEF);
    #1;
    chk("sh_acc_stall", {31'b0, stall}, 32'd1);
    tick;
    chk("sh_wdata", bus.l1d_wdata_o, 32'hBEEF_BEEF);
    chk("sh_be", {28'b0, bus.l1d_be_o}, 32'hC);
    chk("sh_we", {31'b0, bus.l1d_we_o}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) gnt = 1'b1;
      #1;
      chk("sh_req_hold", {31'b0, bus.l1d_req_o}, 32'd1);
      chk("sh_stall_req", {31'b0, stall}, 32'd1);
      tick;
    end
    gnt = 1'b0;
    chk("sh_req_drop", {31'b0, bus.l1d_req_o}, 32'd0);
    chk("sh_stall_rsp", {31'b0, stall}, 32'd1);
    tick;
    rvalid = 1'b1; rdata_bus = 32'hFFFF_FFFF;
    #1;
    chk("sh_stall_rsp2", {31'b0, stall}, 32'd1);
    tick;
    rvalid = 1'b0;
    chk("sh_done", {31'b0, done}, 32'd1);
    chk("sh_rdata", rdata, 32'd0);
    chk("sh_stall_done", {31'b0, stall}, 32'd0);
    mem_valid = 1'b0;
    tick;

    // timeout: grant never comes
    set_op(1'b0, 2'b10, 1'b0, 32'h5000, 32'h0);
    tick;
    nreq = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) break;
      if (bus.l1d_req_o) nreq++;
      tick;
    end
    chk("to_req_cycles", nreq, 32'd8);
    chk("to_done", {31'b0, done}, 32'd1);
    chk("to_err", {31'b0, bus_err}, 32'd1);
    chk("to_rdata", rdata, 32'd0);
    mem_valid = 1'b0;
    tick;
    chk("to_err_clear", {31'b0, bus_err}, 32'd0);
    run_vec(vt[4]);

    // flush in REQ before grant
    set_op(1'b0, 2'b10, 1'b0, 32'h6000, 32'h0);
    tick;
    chk("frq_req", {31'b0, bus.l1d_req_o}, 32'd1);
    flush = 1'b1; mem_valid = 1'b0;
    tick;
    flush = 1'b0;
    chk("frq_req_off", {31'b0, bus.l1d_req_o}, 32'd0);
    chk("frq_stall", {31'b0, stall}, 32'd0);
    chk("frq_done", {31'b0, done}, 32'd0);
    tick;
    chk("frq_done2", {31'b0, done}, 32'd0);

    // flush in RSP: response still consumed, no completion reported
    set_op(1'b0, 2'b10, 1'b0, 32'h6004, 32'h0);
    tick;
    gnt = 1'b1;
    tick;
    gnt = 1'b0; flush = 1'b1; mem_valid = 1'b0;
    #1;
    chk("frs_stall", {31'b0, stall}, 32'd1);
    tick;
    flush = 1'b0; rvalid = 1'b1; rdata_bus = 32'hCAFE_F00D;
    #1;
    chk("frs_stall2", {31'b0, stall}, 32'd1);
    tick;
    rvalid = 1'b0;
    chk("frs_done", {31'b0, done}, 32'd0);
    chk("frs_idle", {31'b0, stall}, 32'd0);
    chk("frs_rdata", rdata, 32'd0);
    tick;
    chk("frs_done2", {31'b0, done}, 32'd0);

    // reset while waiting for a response, then a stale rvalid
    set_op(1'b0, 2'b10, 1'b0, 32'h7000, 32'h0);
    tick;
    gnt = 1'b1;
    tick;
    gnt = 1'b0; rst = 1'b1; mem_valid = 1'b0;
    tick;
    rst = 1'b0;
    chk("rr_req", {31'b0, bus.l1d_req_o}, 32'd0);
    chk("rr_addr", bus.l1d_addr_o, 32'd0);
    chk("rr_stall", {31'b0, stall}, 32'd0);
    chk("rr_done", {31'b0, done}, 32'd0);
    chk("rr_err", {31'b0, bus_err}, 32'd0);
    rvalid = 1'b1; rdata_bus = 32'h1111_2222;
    tick;
    rvalid = 1'b0;
    chk("rr_stale", {31'b0, done}, 32'd0);
    tick;
    chk("rr_stale2", {31'b0, done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
